bpred_resolve_queue: RTL and testbench

In-order resolution queue that sits directly downstream of the 2-bit branch predictor. Every prediction the predictor issues is held here until the branch resolves. At resolution the block compares predicted and actual direction, drives the predictor's update inputs, and pulses a misprediction flush that also discards all younger in-flight predictions. It keeps saturating branch and misprediction counters for performance monitoring.

---
 rtl/bpred_pkg.sv | 17 +
 rtl/bpred_sat_cnt.sv | 20 ++
 rtl/bpred_resolve_queue.sv | 99 +++++++++
 tb/tb_bpred_resolve_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared constants and update bundle for the branch predictor path
package bpred_pkg;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;

  // Predictor-side update bundle: request strobe, actual outcome, flush flag.
  typedef struct packed {
    logic valid;
    logic result;
    logic mispredict;
  } bpred_update_t;

endpackage

// File: rtl/bpred_sat_cnt.sv
// rtl/bpred_sat_cnt.sv - saturating up-counter for performance statistics
module bpred_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  // Holds at all-ones rather than wrapping so a long run never reads as small.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/bpred_resolve_queue.sv
// rtl/bpred_resolve_queue.sv - in-order resolution queue with misprediction flush
module bpred_resolve_queue
  import bpred_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_valid,
  output logic                       upd_result,
  output logic                       mispredict,
  output logic                       res_underflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           branch_cnt,
  output logic [CNT_W-1:0]           mispred_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    occ;
  bpred_update_t    upd_q;
  logic             und_q;
  logic             push;
  logic             pop;
  logic             miss;

  // Readiness comes from registered occupancy only: a full queue refuses even if it pops.
  assign pred_ready = (occ < FULL);
  assign count      = occ;
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && (occ != '0);
  assign miss       = pop && (mem[rd_ptr] != res_taken);

  always_ff @(posedge clk) begin
    if (push && !miss) begin
      mem[wr_ptr] <= pred_taken;
    end
  end

  // A miss discards every younger entry, including one arriving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (miss) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= '0;
      und_q <= 1'b0;
    end else begin
      upd_q.valid      <= pop;
      upd_q.result     <= pop && res_taken;
      upd_q.mispredict <= miss;
      und_q            <= res_valid && (occ == '0);
    end
  end

  assign upd_valid     = upd_q.valid;
  assign upd_result    = upd_q.result;
  assign mispredict    = upd_q.mispredict;
  assign res_underflow = und_q;

  bpred_sat_cnt #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .value (branch_cnt)
  );

  bpred_sat_cnt #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss),
    .value (mispred_cnt)
  );

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// tb/tb_bpred_resolve_queue.sv - scoreboard bench for the branch resolution queue
module tb_bpred_resolve_queue;
  import bpred_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pred_valid = 1'b0;
  logic             pred_taken = 1'b0;
  logic             res_valid = 1'b0;
  logic             res_taken = 1'b0;
  logic             pred_ready;
  logic             upd_valid;
  logic             upd_result;
  logic             mispredict;
  logic             res_underflow;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  bpred_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_ready    (pred_ready),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .upd_valid     (upd_valid),
    .upd_result    (upd_result),
    .mispredict    (mispredict),
    .res_underflow (res_underflow),
    .count         (count),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit result;
    bit mis;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp_upd[$];
  int   exp_und[$];
  bit   mq[$];
  int   m_branch = 0;
  int   m_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Model: the queue is a list of outstanding predictions, oldest first.
  task automatic step(input bit pv, input bit pt, input bit rv, input bit rt);
    bit push;
    bit e;
    pred_valid = pv;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    push = pv && (mq.size() < DEPTH);
    if (rv && mq.size() == 0) exp_und.push_back(cyc + 1);
    if (rv && mq.size() != 0) begin
      e = mq.pop_front();
      exp_upd.push_back('{cyc + 1, rt, e != rt});
      m_branch = sat_inc(m_branch);
      if (e != rt) begin
        m_mis = sat_inc(m_mis);
        mq.delete();
        push = 1'b0;
      end
    end
    if (push) mq.push_back(pt);
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    check("count", int'(count), mq.size());
    check("pred_ready", int'(pred_ready), int'(mq.size() < DEPTH));
    check("branch_cnt", int'(branch_cnt), m_branch);
    check("mispred_cnt", int'(mispred_cnt), m_mis);
  endtask

  task automatic model_clear();
    mq.delete();
    exp_upd.delete();
    exp_und.delete();
    m_branch = 0;
    m_mis = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_upd_valid"}, int'(upd_valid), 0);
    check({tag, "_upd_result"}, int'(upd_result), 0);
    check({tag, "_mispredict"}, int'(mispredict), 0);
    check({tag, "_underflow"}, int'(res_underflow), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_branch_cnt"}, int'(branch_cnt), 0);
    check({tag, "_mispred_cnt"}, int'(mispred_cnt), 0);
    check({tag, "_pred_ready"}, int'(pred_ready), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected updates as the DUT presents them.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ue;
    if (rst_n) begin
      if (upd_valid) begin
        if (exp_upd.size() == 0) begin
          check("upd_unexpected", 1, 0);
        end else begin
          e = exp_upd.pop_front();
          check("upd_cycle", cyc, e.cyc);
          check("upd_result", int'(upd_result), int'(e.result));
          check("mispredict", int'(mispredict), int'(e.mis));
        end
      end else begin
        check("mispredict_idle", int'(mispredict), 0);
        if (exp_upd.size() != 0 && exp_upd[0].cyc <= cyc) begin
          check("upd_missing", 0, 1);
          void'(exp_upd.pop_front());
        end
      end
      while (exp_und.size() != 0 && exp_und[0] < cyc) begin
        check("underflow_missing", 0, 1);
        void'(exp_und.pop_front());
      end
      ue = (exp_und.size() != 0 && exp_und[0] == cyc);
      if (ue) void'(exp_und.pop_front());
      check("res_underflow", int'(res_underflow), int'(ue));
    end
  end

  initial begin : stim
    bit pat[4];
    bit rt;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();

    for (int i = 0; i < 4; i++) step(1, pat[i], 0, 0);
    step(1, 0, 0, 0);
    check("fill_count", int'(count), 4);

    for (int i = 0; i < 4; i++) step(0, 0, 1, pat[i]);
    check("hits_branch_cnt", int'(branch_cnt), 4);
    check("hits_mispred_cnt", int'(mispred_cnt), 0);

    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    check("flush_count", int'(count), 0);
    check("flush_mispred_cnt", int'(mispred_cnt), 1);

    for (int i = 0; i < 4; i++) step(1, pat[i], 0, 0);
    step(1, 0, 1, 1);
    check("full_pop_count", int'(count), 3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, mq[0]);

    step(0, 0, 1, 1);
    step(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rt = $urandom_range(0, 1);
      if (mq.size() != 0) rt = ($urandom_range(0, 3) == 0) ? !mq[0] : mq[0];
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0, rt);
    end
    step(0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, TAKEN, 0, 0);
      step(0, 0, 1, NOT_TAKEN);
    end
    check("sat_mispred_cnt", int'(mispred_cnt), CMAX);
    check("sat_branch_cnt", int'(branch_cnt), CMAX);

    step(1, 1, 0, 0);
    pred_valid = 1'b1;
    res_valid  = 1'b1;
    res_taken  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
